s100_bus_hold_ctrl: RTL
=======================

Name: s100_bus_hold_ctrl

Overview:
- Sequences S100 bus hand-over from the on-board Z80 to up to NREQ external temporary masters (TMA/DMA).
- Arbitrates the synchronized hold requests with fixed priority and asks the CPU for the bus.
- Drives the select line of the control-bus output mux, which forces the S100 control outputs to 0 while released.
- Enforces a bus turn-around dead time before and after each grant, and a maximum hold time.

Parameters:
- NREQ, 4, number of external hold requesters; index 0 has highest priority.
- DEAD_CYCLES, 8, clock cycles between mux release and grant, and between grant drop and mux restore (1..255).
- MAX_HOLD, 65535, maximum cycles a grant may be held before forced release (1..2^20-1).

Ports:
- pll0_250MHz  input  1  system clock, 250 MHz.
- n_reset  input  1  asynchronous active-low reset.
- hold_req  input  NREQ  asynchronous hold requests from S100 masters, active high.
- cpu_busack  input  1  CPU bus-acknowledge, active high, synchronous to pll0_250MHz.
- err_clr  input  1  single-cycle pulse; clears timeout_err.
- cpu_busrq  output  1  bus request to CPU, active high.
- ctl_select  output  1  to control-mux select; 1 = control outputs driven 0 (bus released).
- grant  output  NREQ  one-hot grant to the winning requester.
- phlda  output  1  S100 pHLDA, high while any grant is active.
- active_id  output  clog2(NREQ)  index of the current or last winner.
- timeout_err  output  1  sticky flag; a MAX_HOLD forced release occurred.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; synchronizers, counters and lockout mask cleared.
- hold_req passes through a 2-flop synchronizer per bit (req_s). All decisions use req_s & ~lockout.
- IDLE: if any eligible req_s, latch the lowest index into active_id, set cpu_busrq=1 next cycle, go BUSRQ.
- BUSRQ: wait for cpu_busack=1, then set ctl_select=1, load the dead counter with DEAD_CYCLES and go DISABLE.
  - If req_s[active_id] drops first: cpu_busrq=0, go RESTORE.
- DISABLE: decrement each cycle. At 0: grant[active_id]=1, phlda=1, clear the hold counter, go GRANTED.
  - If the request drops during DISABLE: go RESTORE with ctl_select still 1; grant is never asserted.
- GRANTED: the hold counter increments each cycle. Release when either:
  - req_s[active_id]=0 (normal), or
  - counter reaches MAX_HOLD (forced: timeout_err=1, lockout[active_id]=1).
  - On release: grant=0 and phlda=0 on the same edge, dead counter reloaded, go RELEASE.
- Higher-priority requests arriving during BUSRQ..GRANTED do not preempt. They win at the next IDLE arbitration.
- RELEASE: decrement. At 0: ctl_select=0 and cpu_busrq=0, go RESTORE.
- RESTORE: ctl_select=0, cpu_busrq=0. Wait for cpu_busack=0, then go IDLE.
  - The CPU always regains the bus between two grants, so there is no back-to-back hand-over.
- Latency from the hold_req edge to the grant edge equals 2 sync cycles + 1 (IDLE) + busack wait + 1 + DEAD_CYCLES.
- Lockout: lockout[i] clears when req_s[i]=0.
- timeout_err clears on err_clr. If set and clear happen in the same cycle, set wins.
- Invariants:
  - grant is one-hot or zero.
  - grant!=0 implies ctl_select=1.
  - phlda equals |grant.
  - ctl_select never falls while grant!=0.

Decomposition:
- Shared package s100_bus_pkg:
  - state enum (IDLE, BUSRQ, DISABLE, GRANTED, RELEASE, RESTORE)
  - DEAD/HOLD counter width constants
  - function for the lowest-set-bit priority encode.
- Sub-module sync2_bus (parameterised-width 2-flop synchronizer, n_reset async clear). It is reused by other S100 input paths.

Test Plan:
- Reset mid-GRANTED (NREQ=4, DEAD_CYCLES=4, req[2] granted) -> n_reset low gives all outputs 0 immediately. After release with req low, the block stays in IDLE.
- req[2]=1, cpu_busack 3 cycles after cpu_busrq -> ctl_select rises 1 cycle after busack and grant=4'b0100 4 cycles later. Drop req[2] -> grant 0 after 2 sync cycles, ctl_select 0 after a further 4 cycles, cpu_busrq 0 together with it.
- req[3] and req[1] rise on the same cycle -> active_id=1, grant=4'b0010. After req[1] drops and busack falls -> new cycle with grant=4'b1000.
- req[0] rises while req[3] is GRANTED -> no preemption. grant[3] holds until req[3] drops, then req[0] is granted after a full RESTORE/IDLE/BUSRQ cycle.
- MAX_HOLD=16, req[1] held high -> grant drops after 16 granted cycles and timeout_err=1. req[1] is not re-granted while it stays high; err_clr pulse gives timeout_err=0.
- req[2] pulses high for 5 cycles and drops before busack -> cpu_busrq drops, ctl_select never rises, grant stays 0.

Source files
------------

// File: rtl/s100_bus_pkg.sv
// Shared definitions for the S100 bus hold/hand-over logic.
package s100_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSRQ   = 3'd1,
        ST_DISABLE = 3'd2,
        ST_GRANTED = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RESTORE = 3'd5
    } bus_state_e;

    localparam int DEAD_W = 8;
    localparam int HOLD_W = 20;
    localparam int PRIO_W = 32;

    // Index of the lowest set bit (highest priority); 0 when the vector is empty.
    function automatic int lowest_set(input logic [PRIO_W-1:0] vec);
        lowest_set = 0;
        for (int i = PRIO_W - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = i;
        end
    endfunction

endpackage

// File: rtl/sync2_bus.sv
// Parameterised-width two-flop synchronizer with asynchronous clear.
module sync2_bus #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments make both stages sample on the same edge,
    // so the value really takes two clocks to cross.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/s100_bus_hold_ctrl.sv
// Hands the S100 bus from the Z80 to one of NREQ temporary masters, with
// turn-around dead time on both sides of the grant and a maximum hold time.
module s100_bus_hold_ctrl
    import s100_bus_pkg::*;
#(
    parameter int  NREQ        = 4,
    parameter int  DEAD_CYCLES = 8,
    parameter int  MAX_HOLD    = 65535,
    localparam int ID_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            pll0_250MHz,
    input  logic            n_reset,
    input  logic [NREQ-1:0] hold_req,
    input  logic            cpu_busack,
    input  logic            err_clr,
    output logic            cpu_busrq,
    output logic            ctl_select,
    output logic [NREQ-1:0] grant,
    output logic            phlda,
    output logic [ID_W-1:0] active_id,
    output logic            timeout_err
);

    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic            rst_n_sync;
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] eligible;
    logic            cur_req;
    logic            timeout_set;

    bus_state_e      state_q,   state_d;
    logic [ID_W-1:0] aid_q,     aid_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [NREQ-1:0] lockout_q, lockout_d;
    logic [DEAD_W-1:0] dead_q,  dead_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic            busrq_q,   busrq_d;
    logic            sel_q,     sel_d;
    logic            phlda_q,   phlda_d;
    logic            terr_q,    terr_d;

    // Reset asserts immediately but leaves reset in step with the clock.
    sync2_bus #(.WIDTH(1)) u_rst_sync (
        .clk_i  (pll0_250MHz),
        .rst_ni (n_reset),
        .d_i    (1'b1),
        .q_o    (rst_n_sync)
    );

    sync2_bus #(.WIDTH(NREQ)) u_req_sync (
        .clk_i  (pll0_250MHz),
        .rst_ni (rst_n_sync),
        .d_i    (hold_req),
        .q_o    (req_s)
    );

    assign eligible = req_s & ~lockout_q;
    assign cur_req  = req_s[aid_q];

    always_comb begin
        // NOTE: every next-state signal gets a default first so that no path
        // through the case statement leaves one unassigned (no latches).
        state_d     = state_q;
        aid_d       = aid_q;
        grant_d     = grant_q;
        dead_d      = dead_q;
        hold_d      = hold_q;
        busrq_d     = busrq_q;
        sel_d       = sel_q;
        phlda_d     = phlda_q;
        timeout_set = 1'b0;
        lockout_d   = lockout_q & req_s;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    aid_d   = ID_W'(lowest_set(PRIO_W'(eligible)));
                    busrq_d = 1'b1;
                    state_d = ST_BUSRQ;
                end
            end
            ST_BUSRQ: begin
                if (!cur_req) begin
                    busrq_d = 1'b0;
                    state_d = ST_RESTORE;
                end else if (cpu_busack) begin
                    sel_d   = 1'b1;
                    dead_d  = DEAD_LOAD;
                    state_d = ST_DISABLE;
                end
            end
            ST_DISABLE: begin
                if (!cur_req) begin
                    busrq_d = 1'b0;
                    state_d = ST_RESTORE;
                end else if (dead_q <= DEAD_W'(1)) begin
                    grant_d        = '0;
                    grant_d[aid_q] = 1'b1;
                    phlda_d        = 1'b1;
                    hold_d         = '0;
                    state_d        = ST_GRANTED;
                end else begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            ST_GRANTED: begin
                if (!cur_req || hold_q == HOLD_LAST) begin
                    if (cur_req) begin
                        timeout_set      = 1'b1;
                        lockout_d[aid_q] = 1'b1;
                    end
                    grant_d = '0;
                    phlda_d = 1'b0;
                    dead_d  = DEAD_LOAD;
                    state_d = ST_RELEASE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (dead_q <= DEAD_W'(1)) begin
                    sel_d   = 1'b0;
                    busrq_d = 1'b0;
                    state_d = ST_RESTORE;
                end else begin
                    dead_d = dead_q - DEAD_W'(1);
                end
            end
            ST_RESTORE: begin
                sel_d   = 1'b0;
                busrq_d = 1'b0;
                if (!cpu_busack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        terr_d = timeout_set | (terr_q & ~err_clr);
    end

    always_ff @(posedge pll0_250MHz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q   <= ST_IDLE;
            aid_q     <= '0;
            grant_q   <= '0;
            lockout_q <= '0;
            dead_q    <= '0;
            hold_q    <= '0;
            busrq_q   <= 1'b0;
            sel_q     <= 1'b0;
            phlda_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aid_q     <= aid_d;
            grant_q   <= grant_d;
            lockout_q <= lockout_d;
            dead_q    <= dead_d;
            hold_q    <= hold_d;
            busrq_q   <= busrq_d;
            sel_q     <= sel_d;
            phlda_q   <= phlda_d;
            terr_q    <= terr_d;
        end
    end

    assign cpu_busrq   = busrq_q;
    assign ctl_select  = sel_q;
    assign grant       = grant_q;
    assign phlda       = phlda_q;
    assign active_id   = aid_q;
    assign timeout_err = terr_q;

endmodule
